// File: rtl/tiny_riscv_defs.sv
// Shared RV32I load/store definitions: funct3 width codes, byte-lane mask
// constants, load/store FSM state encoding and small decode helpers used by
// the decoder and the load/store unit.
// Ports: none (package).
package tiny_riscv_defs;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane write-enable patterns before lane shifting
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } ls_state_e;

  // Misaligned access or a funct3 that is not a legal load/store width.
  // BU/HU exist only for loads.
  function automatic logic ls_fault(input logic       is_store,
                                    input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic f;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_H:    f = addr_lo[0];
      F3_W:    f = (addr_lo != 2'b00);
      F3_BU:   f = is_store;
      F3_HU:   f = is_store | addr_lo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // Byte-lane enables for a legal store
  function automatic logic [3:0] ls_store_mask(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
    logic [3:0] m;
    case (funct3)
      F3_B:    m = MASK_BYTE << addr_lo;
      F3_H:    m = MASK_HALF << {addr_lo[1], 1'b0};
      F3_W:    m = MASK_WORD;
      default: m = MASK_NONE;
    endcase
    return m;
  endfunction

  // Replicate the store operand across all lanes so the mask alone selects
  // the destination bytes.
  function automatic logic [31:0] ls_store_lanes(input logic [2:0]  funct3,
                                                 input logic [31:0] data);
    logic [31:0] w;
    case (funct3)
      F3_B:    w = {4{data[7:0]}};
      F3_H:    w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tiny_riscv_load_store_if.sv
// CPU request/response and word-memory signals of the load/store unit.
// slave modport: the load/store unit; master modport: CPU + memory side.
//   i_req_valid/o_req_ready handshake, i_is_store, i_funct3, i_addr,
//   i_store_data; o_resp_valid pulse with o_load_data/o_fault;
//   o_mem_addr, o_mem_read_strobe, i_mem_data, o_mem_write_data,
//   o_mem_write_mask toward a single-port word memory.
interface tiny_riscv_load_store_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        o_resp_valid;
  logic [31:0] o_load_data;
  logic        o_fault;
  logic [31:0] o_mem_addr;
  logic        o_mem_read_strobe;
  logic [31:0] i_mem_data;
  logic [31:0] o_mem_write_data;
  logic [3:0]  o_mem_write_mask;

  modport slave (
    input  i_req_valid, i_is_store, i_funct3, i_addr, i_store_data, i_mem_data,
    output o_req_ready, o_resp_valid, o_load_data, o_fault,
           o_mem_addr, o_mem_read_strobe, o_mem_write_data, o_mem_write_mask
  );

  modport master (
    output i_req_valid, i_is_store, i_funct3, i_addr, i_store_data, i_mem_data,
    input  o_req_ready, o_resp_valid, o_load_data, o_fault,
           o_mem_addr, o_mem_read_strobe, o_mem_write_data, o_mem_write_mask
  );
endinterface

// File: rtl/tiny_riscv_load_align.sv
// Combinational load alignment: selects the addressed byte/halfword of a
// memory word and sign- or zero-extends it according to funct3.
// Ports: i_word (raw memory word), i_addr_lo (byte offset), i_funct3
// (width code), o_result (aligned 32-bit load value, 0 for illegal codes).
module tiny_riscv_load_align
  import tiny_riscv_defs::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane selection followed by extension
  always_comb begin
    lane_b   = 8'h00;
    lane_h   = 16'h0000;
    o_result = 32'h0000_0000;
    case (i_addr_lo)
      2'b00:   lane_b = i_word[7:0];
      2'b01:   lane_b = i_word[15:8];
      2'b10:   lane_b = i_word[23:16];
      2'b11:   lane_b = i_word[31:24];
      default: lane_b = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      lane_h = i_word[31:16];
    end else begin
      lane_h = i_word[15:0];
    end
    case (i_funct3)
      F3_B:    o_result = {{24{lane_b[7]}}, lane_b};
      F3_H:    o_result = {{16{lane_h[15]}}, lane_h};
      F3_W:    o_result = i_word;
      F3_BU:   o_result = {24'h00_0000, lane_b};
      F3_HU:   o_result = {16'h0000, lane_h};
      default: o_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/tiny_riscv_load_store.sv
// RV32I load/store unit. Accepts one request at a time, checks alignment
// at accept, then drives a single-port word memory: loads take
// READ -> WAIT -> DONE (one-cycle registered read), stores WRITE -> DONE,
// faults go straight to DONE without touching memory.
// Ports: i_Clk (clock), i_Rst (synchronous active-high reset),
// bus (tiny_riscv_load_store_if.slave: CPU request/response + memory).
module tiny_riscv_load_store
  import tiny_riscv_defs::*;
(
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  tiny_riscv_load_store_if.slave         bus
);

  ls_state_e   state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic        fault_q, fault_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] align_s;

  tiny_riscv_load_align u_align (
    .i_word    (bus.i_mem_data),
    .i_addr_lo (addr_q[1:0]),
    .i_funct3  (funct3_q),
    .o_result  (align_s)
  );

  // State and request registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0000_0000;
      store_data_q <= 32'h0000_0000;
      fault_q      <= 1'b0;
      load_data_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      fault_q      <= fault_d;
      load_data_q  <= load_data_d;
    end
  end

  // Next-state logic, request capture and load result update
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    fault_d      = fault_q;
    load_data_d  = load_data_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          is_store_d   = bus.i_is_store;
          funct3_d     = bus.i_funct3;
          addr_d       = bus.i_addr;
          store_data_d = bus.i_store_data;
          if (ls_fault(bus.i_is_store, bus.i_funct3, bus.i_addr[1:0])) begin
            fault_d = 1'b1;
            state_d = DONE;
            // A faulting load reports zero; a faulting store leaves it alone
            if (!bus.i_is_store) begin
              load_data_d = 32'h0000_0000;
            end else begin
              load_data_d = load_data_q;
            end
          end else begin
            fault_d = 1'b0;
            if (bus.i_is_store) begin
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ:    state_d = WAIT;
      WAIT: begin
        load_data_d = align_s;  // memory word is valid this cycle
        state_d     = DONE;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode registered state only
  assign bus.o_req_ready       = (state_q == IDLE);
  assign bus.o_resp_valid      = (state_q == DONE);
  assign bus.o_fault           = (state_q == DONE) & fault_q;
  assign bus.o_load_data       = load_data_q;
  assign bus.o_mem_addr        = addr_q;
  assign bus.o_mem_read_strobe = (state_q == READ);
  assign bus.o_mem_write_mask  = (state_q == WRITE) ? ls_store_mask(funct3_q, addr_q[1:0])
                                                    : MASK_NONE;
  assign bus.o_mem_write_data  = ls_store_lanes(funct3_q, store_data_q);

  // is_store_q is kept for debug visibility of the latched request
  logic unused_s;
  assign unused_s = is_store_q;

endmodule

// File: tb/tb_tiny_riscv_load_store.sv
// Self-checking bench for tiny_riscv_load_store: behavioural word memory,
// reference model of RV32I load/store semantics, directed and random ops.
module tb_tiny_riscv_load_store;

  logic clk;
  logic rst;

  tiny_riscv_load_store_if bus ();

  tiny_riscv_load_store dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory as seen by the unit, and the bench's own expectation of it
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem_rdata;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;
  logic [31:0] last_load;

  int n_checks = 0;
  int n_pass   = 0;

  assign bus.i_mem_data = mem_rdata;

  // Single-port word memory: one-cycle registered read, per-byte write
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (bus.o_mem_read_strobe) mem_rdata <= mem[bus.o_mem_addr[9:2]];
    for (int i = 0; i < 4; i++) begin
      if (bus.o_mem_write_mask[i])
        mem[bus.o_mem_addr[9:2]][8*i +: 8] <= bus.o_mem_write_data[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = a[9:2];
    pl_val = v;
    ref_mem[a[9:2]] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One complete request, checked against the reference rules
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] got_ld,
                       output logic [3:0] got_mask, output logic [31:0] got_wd);
    int size, off, lat, resp_k, n_strb, n_mask;
    logic legal, efault, gfault, overlap, stray, ready_after, addr_ok;
    logic [31:0] eld, v, ewd;
    logic [3:0]  emask;
    legal = 1'b1;
    size  = 1;
    case (f3)
      3'b000: size = 1;
      3'b001: size = 2;
      3'b010: size = 4;
      3'b100: begin size = 1; legal = !st; end
      3'b101: begin size = 2; legal = !st; end
      default: legal = 1'b0;
    endcase
    off    = int'(a[1:0]);
    efault = !legal || ((off % size) != 0);
    lat    = efault ? 1 : (st ? 2 : 3);
    eld    = last_load;
    if (!st) begin
      if (efault) eld = 32'h0;
      else begin
        v = ref_mem[a[9:2]] >> (8 * off);
        case (f3)
          3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
          3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
          3'b100: v = v & 32'hFF;
          3'b101: v = v & 32'hFFFF;
          default: ;
        endcase
        eld = v;
      end
    end
    emask = (efault || !st) ? 4'h0 : 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = 8'(d >> (8 * (i % size)));

    @(negedge clk);
    chk("ready_before", 32'(bus.o_req_ready), 32'h1);
    bus.i_req_valid  = 1'b1;
    bus.i_is_store   = st;
    bus.i_funct3     = f3;
    bus.i_addr       = a;
    bus.i_store_data = d;
    @(posedge clk);
    #1;
    // Garbage on the request lines must be ignored while busy
    bus.i_req_valid  = 1'b0;
    bus.i_is_store   = 1'($urandom);
    bus.i_funct3     = 3'($urandom);
    bus.i_addr       = $urandom;
    bus.i_store_data = $urandom;

    resp_k = 0; n_strb = 0; n_mask = 0; overlap = 1'b0; stray = 1'b0;
    gfault = 1'b0; got_ld = 32'h0; got_mask = 4'h0; got_wd = 32'h0;
    addr_ok = 1'b1; ready_after = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_k != 0) begin
        ready_after = bus.o_req_ready && !bus.o_resp_valid;
        break;
      end
      if (bus.o_mem_read_strobe) begin
        n_strb++;
        if (bus.o_mem_addr != a) addr_ok = 1'b0;
      end
      if (bus.o_mem_write_mask != 4'h0) begin
        n_mask++;
        got_mask = bus.o_mem_write_mask;
        got_wd   = bus.o_mem_write_data;
        if (bus.o_mem_addr != a) addr_ok = 1'b0;
      end
      if (bus.o_mem_read_strobe && bus.o_mem_write_mask != 4'h0) overlap = 1'b1;
      if (bus.o_fault && !bus.o_resp_valid) stray = 1'b1;
      if (bus.o_resp_valid) begin
        resp_k = k;
        gfault = bus.o_fault;
        got_ld = bus.o_load_data;
      end
    end

    chk("resp_latency", 32'(resp_k), 32'(lat));
    chk("fault", 32'(gfault), 32'(efault));
    chk("read_strobes", 32'(n_strb), (!st && !efault) ? 32'h1 : 32'h0);
    chk("mask_cycles", 32'(n_mask), (st && !efault) ? 32'h1 : 32'h0);
    if (st && !efault) begin
      chk("write_mask", 32'(got_mask), 32'(emask));
      chk("write_data", got_wd, ewd);
    end
    chk("load_data", got_ld, eld);
    chk("mem_addr", 32'(addr_ok), 32'h1);
    chk("rd_wr_overlap", 32'(overlap), 32'h0);
    chk("fault_without_resp", 32'(stray), 32'h0);
    chk("ready_after_done", 32'(ready_after), 32'h1);

    if (!st) last_load = eld;
    if (st && !efault) begin
      for (int i = 0; i < 4; i++)
        if (emask[i]) ref_mem[a[9:2]][8*i +: 8] = ewd[8*i +: 8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] ld, wd;
    logic [3:0]  mk;
    int r1, r2;
    logic rdy3;

    rst = 1'b1;
    pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
    bus.i_req_valid = 1'b0; bus.i_is_store = 1'b0; bus.i_funct3 = 3'b000;
    bus.i_addr = 32'h0; bus.i_store_data = 32'h0;
    last_load = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_req_ready), 32'h1);
    chk("rst_resp", 32'(bus.o_resp_valid), 32'h0);
    chk("rst_fault", 32'(bus.o_fault), 32'h0);
    chk("rst_load_data", bus.o_load_data, 32'h0);
    chk("rst_strobe", 32'(bus.o_mem_read_strobe), 32'h0);
    chk("rst_mask", 32'(bus.o_mem_write_mask), 32'h0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'h0);

    for (int w = 0; w < 16; w++) preload(32'h180 + 32'(4 * w), $urandom);
    preload(32'h190, 32'h0403_0201);
    preload(32'h19C, 32'h000F_0E0D);
    rst = 1'b0;

    // Directed cases
    do_op(1'b0, 3'b100, 32'h193, 32'h0, ld, mk, wd);
    chk("lbu_193", ld, 32'h0000_0004);
    do_op(1'b0, 3'b101, 32'h19E, 32'h0, ld, mk, wd);
    chk("lhu_19e", ld, 32'h0000_000F);
    do_op(1'b0, 3'b001, 32'h19C, 32'h0, ld, mk, wd);
    chk("lh_19c", ld, 32'h0000_0E0D);
    do_op(1'b1, 3'b000, 32'h191, 32'h0000_00A5, ld, mk, wd);
    chk("sb_mask", 32'(mk), 32'h2);
    chk("sb_data", wd, 32'hA5A5_A5A5);
    do_op(1'b0, 3'b000, 32'h191, 32'h0, ld, mk, wd);
    chk("lb_191", ld, 32'hFFFF_FFA5);
    do_op(1'b0, 3'b010, 32'h190, 32'h0, ld, mk, wd);
    chk("lw_190", ld, 32'h0403_A501);
    do_op(1'b0, 3'b010, 32'h192, 32'h0, ld, mk, wd);
    chk("lw_misaligned", ld, 32'h0);
    do_op(1'b0, 3'b011, 32'h190, 32'h0, ld, mk, wd);
    chk("funct3_011", ld, 32'h0);
    do_op(1'b1, 3'b001, 32'h191, 32'h1234_5678, ld, mk, wd);
    do_op(1'b1, 3'b100, 32'h190, 32'h1234_5678, ld, mk, wd);

    // Back-to-back: SW then LW with valid held high
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_is_store = 1'b1; bus.i_funct3 = 3'b010;
    bus.i_addr = 32'h198; bus.i_store_data = 32'h1122_3344;
    @(posedge clk);
    #1;
    bus.i_is_store = 1'b0;
    r1 = 0; r2 = 0; rdy3 = 1'b0; ld = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) rdy3 = bus.o_req_ready;
      if (bus.o_resp_valid) begin
        if (r1 == 0) r1 = k;
        else begin r2 = k; ld = bus.o_load_data; end
      end
      if (k == 6) bus.i_req_valid = 1'b0;
    end
    chk("b2b_store_resp", 32'(r1), 32'h2);
    chk("b2b_ready", 32'(rdy3), 32'h1);
    chk("b2b_load_resp", 32'(r2), 32'h6);
    chk("b2b_load_data", ld, 32'h1122_3344);
    ref_mem[32'h198 >> 2] = 32'h1122_3344;
    last_load = 32'h1122_3344;

    // Randomized traffic in the preloaded window
    for (int n = 0; n < 60; n++) begin
      do_op(1'($urandom), 3'($urandom_range(0, 7)), 32'h180 + $urandom_range(0, 63),
            $urandom, ld, mk, wd);
    end

    // Reset during WRITE of a word store
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_is_store = 1'b1; bus.i_funct3 = 3'b010;
    bus.i_addr = 32'h194; bus.i_store_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    chk("write_state_mask", 32'(bus.o_mem_write_mask), 32'hF);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_write_mask", 32'(bus.o_mem_write_mask), 32'h0);
    chk("rst_write_resp", 32'(bus.o_resp_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_write_ready", 32'(bus.o_req_ready), 32'h1);
    chk("rst_write_no_resp", 32'(bus.o_resp_valid), 32'h0);

    // Reset during WAIT of a load: no response, load result cleared
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_is_store = 1'b0; bus.i_funct3 = 3'b010;
    bus.i_addr = 32'h190;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_resp", 32'(bus.o_resp_valid), 32'h0);
    chk("rst_wait_load_data", bus.o_load_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", 32'(bus.o_req_ready), 32'h1);
    chk("rst_wait_no_resp", 32'(bus.o_resp_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
